hack_mem_arbiter: RTL and testbench

//  Shares the single-port Hack data RAM between the HackCPU data port and an external
//  DMA/debug requester. Sequences each RAM access (grant, wait states, data return).

---
 rtl/hack_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_hack_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hack_mem_arbiter.sv
// Arbitrates the single-port Hack data RAM between the CPU data port and a DMA/debug port.
// Build option: define HACK_ARB_RR_EN for strict round-robin instead of CPU priority.
module hack_mem_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int RAM_LAT     = 1,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: cpu_req is held until cpu_stall is seen low; dma_req is held until
    // the dma_gnt pulse; dma_rvalid pulses once per granted DMA read.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d, state_cur;
    logic              owner_q, owner_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              dma_pick;
    logic              cpu_grant;
    logic              cpu_done;
    logic              acc_we;

`ifdef HACK_ARB_RR_EN
    logic              rr_dma_pri_q, rr_dma_pri_d;

    always_comb begin
        dma_pick     = dma_req && (!cpu_req || rr_dma_pri_q);
        rr_dma_pri_d = rr_dma_pri_q;
        if ((cpu_grant || dma_gnt) && cpu_req && dma_req) begin
            rr_dma_pri_d = cpu_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_dma_pri_q <= 1'b0;
        end else begin
            rr_dma_pri_q <= rr_dma_pri_d;
        end
    end
`else
    logic [3:0]        run_cnt_q, run_cnt_d;

    always_comb begin
        dma_pick  = dma_req && (!cpu_req || (run_cnt_q == 4'(MAX_CPU_RUN)));
        run_cnt_d = run_cnt_q;
        if (!dma_req || dma_gnt) begin
            run_cnt_d = 4'd0;
        end else if (cpu_grant && (run_cnt_q != 4'(MAX_CPU_RUN))) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_q <= 4'd0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end
`endif

    // IDLE with a pending request behaves as GRANT in the same cycle; the register
    // itself only ever holds IDLE or WAIT.
    always_comb begin
        state_cur = state_q;
        if ((state_q == IDLE) && reset && (cpu_req || dma_req)) begin
            state_cur = GRANT;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_rdata   = cpu_rdata_q;
        dma_rdata   = dma_rdata_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        dma_gnt     = 1'b0;
        dma_rvalid  = 1'b0;
        cpu_grant   = 1'b0;
        cpu_done    = 1'b0;
        acc_we      = 1'b0;
        case (state_cur)
            IDLE: begin
            end
            GRANT: begin
                ram_en = 1'b1;
                if (dma_pick) begin
                    ram_we    = dma_we;
                    ram_addr  = dma_addr;
                    ram_wdata = dma_wdata;
                    dma_gnt   = 1'b1;
                    owner_d   = 1'b1;
                    acc_we    = dma_we;
                end else begin
                    ram_we    = cpu_we;
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                    cpu_grant = 1'b1;
                    owner_d   = 1'b0;
                    acc_we    = cpu_we;
                end
                if (acc_we) begin
                    state_d  = IDLE;
                    cpu_done = cpu_grant;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = 3'd0;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 3'(RAM_LAT - 1)) begin
                    state_d = IDLE;
                    // Read data is forwarded in the capture cycle so the CPU can
                    // consume it as soon as the stall drops.
                    if (owner_q) begin
                        dma_rvalid  = 1'b1;
                        dma_rdata   = ram_rdata;
                        dma_rdata_d = ram_rdata;
                    end else begin
                        cpu_done    = 1'b1;
                        cpu_rdata   = ram_rdata;
                        cpu_rdata_d = ram_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_stall = reset && cpu_req && !cpu_done;
    assign dbg_state = state_cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            wait_cnt_q  <= 3'd0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a 1-cycle-latency RAM model.
module tb_hack_mem_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              dma_gnt, dma_rvalid;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0]       exp_q [$];
    logic [15:0]       exp_v;
    bit                pat [10];
    int                n_cmp;
    int                n_err;

    hack_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(1), .MAX_CPU_RUN(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model, read latency 1
    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ram_en"}, ram_en, 0);
        check_eq({tag, "_ram_we"}, ram_we, 0);
        check_eq({tag, "_ram_addr"}, ram_addr, 0);
        check_eq({tag, "_dma_gnt"}, dma_gnt, 0);
        check_eq({tag, "_dma_rvalid"}, dma_rvalid, 0);
        check_eq({tag, "_cpu_stall"}, cpu_stall, 0);
        check_eq({tag, "_cpu_rdata"}, cpu_rdata, 0);
        check_eq({tag, "_dma_rdata"}, dma_rdata, 0);
        check_eq({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();
        mem[15'h7FFF] = 16'hFFFF;
`ifdef HACK_ARB_RR_EN
        pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

        // reset state
        @(negedge clk);
        check_all_zero("reset");

        // CPU write @16 = 0x00AB
        next_cycle();
        reset = 1'b1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'd16; cpu_wdata = 16'h00AB;
        @(negedge clk);
        check_eq("wr_ram_en", ram_en, 1);
        check_eq("wr_ram_we", ram_we, 1);
        check_eq("wr_ram_addr", ram_addr, 16);
        check_eq("wr_ram_wdata", ram_wdata, 16'h00AB);
        check_eq("wr_stall", cpu_stall, 0);
        check_eq("wr_state", dbg_state, 1);

        // CPU read @16: stall one cycle, data in cycle 2
        next_cycle();
        cpu_we = 0;
        @(negedge clk);
        check_eq("rd1_ram_en", ram_en, 1);
        check_eq("rd1_ram_we", ram_we, 0);
        check_eq("rd1_stall", cpu_stall, 1);
        next_cycle();
        @(negedge clk);
        check_eq("rd2_stall", cpu_stall, 0);
        check_eq("rd2_rdata", cpu_rdata, 16'h00AB);
        check_eq("rd2_ram_en", ram_en, 0);
        check_eq("rd2_state", dbg_state, 2);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_eq("rd3_hold", cpu_rdata, 16'h00AB);
        check_eq("rd3_ram_en", ram_en, 0);
        check_eq("rd3_stall", cpu_stall, 0);

        // DMA read @0x7FFF
        next_cycle();
        dma_req = 1; dma_we = 0; dma_addr = 15'h7FFF;
        @(negedge clk);
        check_eq("dr_gnt", dma_gnt, 1);
        check_eq("dr_ram_addr", ram_addr, 15'h7FFF);
        check_eq("dr_rvalid_early", dma_rvalid, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_eq("dr_rvalid", dma_rvalid, 1);
        check_eq("dr_rdata", dma_rdata, 16'hFFFF);
        check_eq("dr_gnt_low", dma_gnt, 0);
        next_cycle();
        @(negedge clk);
        check_eq("dr_rvalid_pulse", dma_rvalid, 0);
        check_eq("dr_rdata_hold", dma_rdata, 16'hFFFF);

        // DMA write @5 then CPU read back
        next_cycle();
        dma_req = 1; dma_we = 1; dma_addr = 15'd5; dma_wdata = 16'h1234;
        @(negedge clk);
        check_eq("dw_gnt", dma_gnt, 1);
        check_eq("dw_ram_we", ram_we, 1);
        check_eq("dw_ram_wdata", ram_wdata, 16'h1234);
        check_eq("dw_rvalid", dma_rvalid, 0);
        next_cycle();
        idle_inputs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'd5;
        @(negedge clk);
        check_eq("cr_stall1", cpu_stall, 1);
        next_cycle();
        @(negedge clk);
        check_eq("cr_stall2", cpu_stall, 0);
        check_eq("cr_rdata", cpu_rdata, 16'h1234);

        // both requesters held high: grant pattern
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            cpu_req = 1; cpu_we = 1; cpu_addr = 15'(100 + i); cpu_wdata = 16'(i);
            dma_req = 1; dma_we = 1; dma_addr = 15'(200 + i); dma_wdata = 16'(i + 50);
            exp_q.push_back({pat[i], pat[i] ? 15'(200 + i) : 15'(100 + i)});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            check_eq($sformatf("grant_%0d", i), {dma_gnt, ram_addr}, exp_v);
            check_eq($sformatf("grant_stall_%0d", i), cpu_stall, exp_v[15]);
        end

        // reset in the middle of a DMA read with dma_req still high
        next_cycle();
        idle_inputs();
        dma_req = 1; dma_we = 0; dma_addr = 15'h7FFF;
        @(negedge clk);
        check_eq("mr_gnt", dma_gnt, 1);
        next_cycle();
        cpu_req = 1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("mr");
        next_cycle();
        @(negedge clk);
        check_eq("mr_gnt_held", dma_gnt, 0);
        check_eq("mr_rvalid_held", dma_rvalid, 0);
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        check_all_zero("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
